// File: rtl/upscale_2x2_pkg.sv
// Shared definitions for the 2x2 pixel-replication upscaler.
//   state_t    : output sequencer states
//   addr_width : address bits needed to index a given number of entries
//   len_width  : width of a pointer/length that must also hold the full count
package upscale_2x2_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ACT0 = 3'd1,
        S_HB0  = 3'd2,
        S_ACT1 = 3'd3,
        S_HB1  = 3'd4
    } state_t;

    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // One extra bit so a pointer can reach LINE_SIZE_MAX itself (saturation value).
    function automatic int len_width(input int depth);
        return addr_width(depth) + 1;
    endfunction

endpackage

// File: rtl/upscale_linebuf.sv
// Ping-pong line buffer: simple dual-port RAM, two banks selected by the
// address MSB, one write port and one registered read port.
//   clk   : clock
//   we    : write enable;      waddr/wdata : write address and data
//   re    : read enable;       raddr       : read address
//   rdata : read data, valid the clock after re (held while re=0)
module upscale_linebuf #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    (* ram_style = "block" *) logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/upscale_2x2.sv
// 2x2 pixel-replication upscaler for the de/hs/vs video stream.
// Each input line is stored in one bank of a ping-pong buffer, then emitted
// twice with every pixel repeated, using internally generated line timing.
//   clk, rst      : clock, asynchronous active-low reset
//   bypass        : 1 = registered pass-through (sampled in vertical blanking)
//   di_i/de_i     : input pixel and valid
//   hs_i/vs_i     : input horizontal blanking / frame active
//   do_o/de_o     : output pixel and valid
//   hs_o/vs_o     : output horizontal blanking / frame active
//   err_o         : sticky overrun flag, cleared on vs_i rising edge
module upscale_2x2
    import upscale_2x2_pkg::*;
#(
    parameter int LINE_SIZE_MAX = 1024,
    parameter int PIXEL_WIDTH   = 8,
    parameter int HBLANK_OUT    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   bypass,
    input  logic [PIXEL_WIDTH-1:0] di_i,
    input  logic                   de_i,
    input  logic                   hs_i,
    input  logic                   vs_i,
    output logic [PIXEL_WIDTH-1:0] do_o,
    output logic                   de_o,
    output logic                   hs_o,
    output logic                   vs_o,
    output logic                   err_o
);

    localparam int AW = addr_width(LINE_SIZE_MAX);
    localparam int PW = len_width(LINE_SIZE_MAX);
    localparam int HW = addr_width(HBLANK_OUT);

    state_t                state_q, state_d;
    logic                  wsel_q, wsel_d, rsel_q, rsel_d;
    logic [1:0]            pending_q, pending_d;
    logic [PW-1:0]         wptr_q, wptr_d;
    logic [1:0][PW-1:0]    len_q, len_d;
    logic                  drop_q, drop_d;
    logic                  de_in_q, de_in_d, vs_in_q, vs_in_d;
    logic                  err_q, err_d, bypass_q, bypass_d;
    logic [PW-1:0]         rptr_q, rptr_d;
    logic                  phase_q, phase_d;
    logic [HW-1:0]         hb_q, hb_d;
    logic                  de_s1_q, de_s1_d, hs_s1_q, hs_s1_d;
    logic [PIXEL_WIDTH-1:0] do_q, do_d;
    logic                  de_o_q, de_o_d, hs_o_q, hs_o_d, vs_o_q, vs_o_d;

    logic                  first_px, drop_now, eol, we, rd_en, line_done;
    logic                  last_word, de_act, drained, vb_drained;
    logic [PIXEL_WIDTH-1:0] rdata;

    // Write side. A line whose first pixel finds its target bank still
    // pending is discarded entirely, which also guarantees the bank under
    // readout is never overwritten.
    assign first_px = de_i && !de_in_q;
    assign drop_now = first_px ? pending_q[wsel_q] : drop_q;
    assign eol      = de_in_q && !de_i && !bypass_q;
    assign we       = de_i && !bypass_q && !drop_now && (wptr_q < PW'(LINE_SIZE_MAX));

    // "Drained" also requires no line in flight on the write side, so a line
    // whose end has not yet been detected still holds off vs_o falling.
    assign drained    = (state_q == S_IDLE) && (pending_q == 2'b00) && (wptr_q == '0) && !de_in_q;
    assign vb_drained = !vs_i && drained;

    upscale_linebuf #(
        .ADDR_W (AW + 1),
        .DATA_W (PIXEL_WIDTH)
    ) u_linebuf (
        .clk   (clk),
        .we    (we),
        .waddr ({wsel_q, wptr_q[AW-1:0]}),
        .wdata (di_i),
        .re    (rd_en),
        .raddr ({rsel_q, rptr_q[AW-1:0]}),
        .rdata (rdata)
    );

    // Output sequencer: two active passes over the same bank, each followed
    // by HBLANK_OUT blanking clocks. Words are read on phase 0 and held for
    // phase 1 by the RAM read register.
    assign last_word = (rptr_q == (len_q[rsel_q] - PW'(1)));
    assign de_act    = (state_q == S_ACT0) || (state_q == S_ACT1);

    always_comb begin
        state_d   = state_q;
        rptr_d    = rptr_q;
        phase_d   = phase_q;
        hb_d      = hb_q;
        rd_en     = 1'b0;
        line_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pending_q[rsel_q]) begin
                    state_d = S_ACT0;
                    rptr_d  = '0;
                    phase_d = 1'b0;
                end
            end
            S_ACT0, S_ACT1: begin
                rd_en   = !phase_q;
                phase_d = !phase_q;
                if (phase_q) begin
                    if (last_word) begin
                        state_d = (state_q == S_ACT0) ? S_HB0 : S_HB1;
                        hb_d    = '0;
                    end else begin
                        rptr_d = rptr_q + PW'(1);
                    end
                end
            end
            S_HB0: begin
                hb_d = hb_q + HW'(1);
                if (hb_q == HW'(HBLANK_OUT - 1)) begin
                    state_d = S_ACT1;
                    rptr_d  = '0;
                    phase_d = 1'b0;
                end
            end
            S_HB1: begin
                hb_d = hb_q + HW'(1);
                if (hb_q == HW'(HBLANK_OUT - 1)) begin
                    state_d   = S_IDLE;
                    line_done = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Buffer bookkeeping, overrun flag, frame/bypass control. Clearing the
    // read bank and setting the write bank on the same clock touch different
    // pending bits, so both simply apply.
    always_comb begin
        wsel_d    = wsel_q;
        rsel_d    = rsel_q;
        wptr_d    = wptr_q;
        len_d     = len_q;
        pending_d = pending_q;
        err_d     = err_q;
        drop_d    = de_i && drop_now;
        bypass_d  = bypass_q;
        de_in_d   = de_i;
        vs_in_d   = vs_i;
        if (we) begin
            wptr_d = wptr_q + PW'(1);
        end
        if (line_done) begin
            pending_d[rsel_q] = 1'b0;
            rsel_d            = ~rsel_q;
        end
        if (!bypass_q && vs_i && !vs_in_q) begin
            err_d = 1'b0;
        end
        if (eol) begin
            wptr_d = '0;
            if (drop_q) begin
                err_d = 1'b1;
            end else if (wptr_q != '0) begin
                len_d[wsel_q]     = wptr_q;
                pending_d[wsel_q] = 1'b1;
                wsel_d            = ~wsel_q;
            end
        end
        if (vb_drained) begin
            wsel_d   = 1'b0;
            rsel_d   = 1'b0;
            wptr_d   = '0;
            bypass_d = bypass;
        end
    end

    // Output stage: control is delayed one clock to line up with the RAM
    // read register, then all outputs share one output register.
    always_comb begin
        de_s1_d = de_act;
        hs_s1_d = !de_act;
        if (bypass_q) begin
            do_d   = di_i;
            de_o_d = de_i;
            hs_o_d = hs_i;
            vs_o_d = vs_i;
        end else begin
            do_d   = de_s1_q ? rdata : '0;
            de_o_d = de_s1_q;
            hs_o_d = hs_s1_q;
            vs_o_d = vs_i || (vs_o_q && !drained);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            wsel_q    <= 1'b0;
            rsel_q    <= 1'b0;
            pending_q <= '0;
            wptr_q    <= '0;
            len_q     <= '0;
            drop_q    <= 1'b0;
            de_in_q   <= 1'b0;
            vs_in_q   <= 1'b0;
            err_q     <= 1'b0;
            bypass_q  <= 1'b0;
            rptr_q    <= '0;
            phase_q   <= 1'b0;
            hb_q      <= '0;
            de_s1_q   <= 1'b0;
            hs_s1_q   <= 1'b1;
            do_q      <= '0;
            de_o_q    <= 1'b0;
            hs_o_q    <= 1'b1;
            vs_o_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wsel_q    <= wsel_d;
            rsel_q    <= rsel_d;
            pending_q <= pending_d;
            wptr_q    <= wptr_d;
            len_q     <= len_d;
            drop_q    <= drop_d;
            de_in_q   <= de_in_d;
            vs_in_q   <= vs_in_d;
            err_q     <= err_d;
            bypass_q  <= bypass_d;
            rptr_q    <= rptr_d;
            phase_q   <= phase_d;
            hb_q      <= hb_d;
            de_s1_q   <= de_s1_d;
            hs_s1_q   <= hs_s1_d;
            do_q      <= do_d;
            de_o_q    <= de_o_d;
            hs_o_q    <= hs_o_d;
            vs_o_q    <= vs_o_d;
        end
    end

    assign do_o  = do_q;
    assign de_o  = de_o_q;
    assign hs_o  = hs_o_q;
    assign vs_o  = vs_o_q;
    assign err_o = err_q;

endmodule

// File: doc/upscale_2x2.md
Name: upscale_2x2

Overview:
- 2x2 pixel-replication upscaler on the team's de/hs/vs video stream; inverse of the 2x2 binning filter.
- Input line of W pixels produces two output lines of 2W pixels; each pixel is emitted twice and each line is emitted twice.
- Ping-pong line buffer decouples input from output; output line and blanking timing are generated internally.
- Sits after the processing chain to restore full resolution for display.

Parameters:
- LINE_SIZE_MAX, 1024, max input pixels per line (buffer depth per bank).
- PIXEL_WIDTH, 8, pixel bit width.
- HBLANK_OUT, 16, clocks of hs_o high between output lines (>=1).

Ports:
- clk  in  1  single clock.
- rst  in  1  reset; asynchronous, active-low.
- bypass  in  1  1 = pass input through, 1-clock registered.
- di_i  in  PIXEL_WIDTH  input pixel, valid when de_i=1.
- de_i  in  1  input data valid; may be sparse.
- hs_i  in  1  input horizontal blanking, high between lines.
- vs_i  in  1  input frame active, low during vertical blanking.
- do_o  out  PIXEL_WIDTH  output pixel.
- de_o  out  1  output data valid.
- hs_o  out  1  output horizontal blanking.
- vs_o  out  1  output frame active.
- err_o  out  1  sticky overrun flag; cleared on vs_i rising edge.

Behaviour:
- Reset (rst=0, async): do_o=0, de_o=0, hs_o=1, vs_o=0, err_o=0. FSM to S_IDLE. wsel=rsel=0, pending[1:0]=0, pointers=0.
- Write side:
  - On de_i=1, write di_i to bank wsel at wptr; wptr++.
  - wptr saturates at LINE_SIZE_MAX; extra pixels are dropped.
  - End of line is the de_i falling edge (de_q & !de_i). Latch len[wsel]=wptr, set pending[wsel], toggle wsel, clear wptr.
  - A zero-length line is never marked pending.
- Overrun:
  - If pending[wsel]=1 when a line's first pixel arrives, all writes of that line are suppressed.
  - At that line's end: err_o=1, wsel not toggled, nothing marked pending.
  - The bank being read is never written.
- Output FSM:
  - S_IDLE: if pending[rsel], go to S_ACT0 with rptr=0, phase=0.
  - S_ACT0 / S_ACT1: 2*len[rsel] cycles; each word is read once and presented for 2 cycles (phase toggles; rptr advances when phase=1). de_o=1, hs_o=0.
  - S_HB0 / S_HB1: HBLANK_OUT cycles with de_o=0, hs_o=1. S_ACT0 goes to S_HB0, then S_ACT1 (rptr reset), then S_HB1.
  - After S_HB1: clear pending[rsel], toggle rsel, go to S_IDLE.
  - Internal length counter width is clog2(LINE_SIZE_MAX)+1.
- Latency:
  - Last input pixel sampled at edge T; end-of-line detected at T+1; S_ACT0 entered at T+2.
  - First de_o=1 with valid do_o at T+4 (RAM read register + output register). de_o/hs_o are delayed identically.
- Input rate: input line period must be >= 4W + 2*HBLANK_OUT + 4 clocks, otherwise overrun.
- Frame handling:
  - vs_o rises 1 clock after vs_i rises.
  - vs_i falling is deferred: vs_o falls when vs_i=0, the FSM is in S_IDLE and pending=0.
  - While vs_i=0 and idle: wsel=rsel=0 and wptr=0.
- Bypass:
  - bypass is sampled only while vs_i=0 and FSM idle.
  - When active, all outputs are the inputs registered 1 clock; the buffer is not written; err_o is held.
- Simultaneous events:
  - End-of-line and S_HB1 completion on the same clock: clear pending[rsel] and set pending[wsel] both apply.
  - The set is on the other bank, so there is no conflict.

Decomposition:
- Shared include upscale_2x2_defs: FSM state encodings (S_IDLE, S_ACT0, S_HB0, S_ACT1, S_HB1) and pointer width localparam.
- Sub-module upscale_linebuf: simple dual-port RAM, 2*LINE_SIZE_MAX x PIXEL_WIDTH, bank bit as address MSB, one write port, one registered read port, RAM_STYLE BLOCK.
- Top holds write control, FSM, frame and bypass logic.

Test Plan:
- One line W=4 (10,20,30,40), HBLANK_OUT=4 -> two output lines each 10,10,20,20,30,30,40,40. de_o high 8 clocks, hs_o high 4 clocks between them. First de_o at T+4. err_o=0.
- Frame of 3 lines W=4, line period 40 clocks -> 6 output lines in order L0,L0,L1,L1,L2,L2. vs_o falls only after the final S_HB1. err_o=0.
- Line period 12 clocks, W=4 -> 3rd line dropped, err_o=1, lines 0/1 output uncorrupted. err_o clears at next vs_i rising.
- LINE_SIZE_MAX=8, feed 10 pixels 1..10 -> output lines of 16 pixels 1,1,...,8,8. Pixels 9,10 are absent.
- Assert rst=0 during S_ACT0 -> outputs immediately de_o=0, hs_o=1, vs_o=0. After release, no output until the next line completes.
- bypass=1 latched in vertical blanking, stream 0x55 with de_i/hs_i/vs_i toggling -> outputs equal inputs delayed exactly 1 clock.
